// File: rtl/sopc_mem_arbiter.sv
// Round-robin arbiter giving N_MST masters serialized access to one single-port RAM.
// One transaction is in flight at a time: capture, strobe the RAM, wait for read data, respond.
`timescale 1ns/1ps

module sopc_mem_arbiter #(
  parameter int N_MST   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_AW  = 16,
  parameter int RAM_LAT = 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_req_i,
  input  logic [N_MST-1:0]        m_we_i,
  input  logic [N_MST*ADDR_W-1:0] m_addr_i,
  input  logic [N_MST*DATA_W-1:0] m_wdata_i,
  input  logic [N_MST*BE_W-1:0]   m_be_i,
  output logic [N_MST-1:0]        m_gnt_o,
  output logic [N_MST-1:0]        m_rvalid_o,
  output logic                    m_err_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic                    ram_ce_o,
  output logic                    ram_we_o,
  output logic [RAM_AW-1:0]       ram_addr_o,
  output logic [DATA_W-1:0]       ram_wdata_o,
  output logic [BE_W-1:0]         ram_be_o,
  input  logic [DATA_W-1:0]       ram_rdata_i
);

  localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_found;
  logic [IDX_W-1:0]    w_winner;
  logic                w_inRange;
  logic [N_MST-1:0]    w_oneHot;

  // Search starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int off = 1; off <= N_MST; off++) begin
      if (!w_found && m_req_i[IDX_W'((int'(r_ptr) + off) % N_MST)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(r_ptr) + off) % N_MST);
      end
    end
  end

  assign w_inRange = ((r_addr >> RAM_AW) == '0);

  always_comb begin
    w_next      = r_state;
    m_gnt_o     = '0;
    m_rvalid_o  = '0;
    m_err_o     = 1'b0;
    m_rdata_o   = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    w_oneHot    = '0;
    w_oneHot[r_idx] = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        m_gnt_o = w_oneHot;
        if (w_inRange) begin
          ram_ce_o    = 1'b1;
          ram_we_o    = r_we;
          ram_addr_o  = r_addr[RAM_AW-1:0];
          ram_wdata_o = r_wdata;
          ram_be_o    = r_be;
        end
        w_next = (r_we || !w_inRange) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        m_rvalid_o = w_oneHot;
        m_err_o    = r_err;
        if (!r_we && !r_err) begin
          m_rdata_o = r_rdata;
        end
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Reset aborts any transaction in flight; ptr starts at the last master so master 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IDX_W'(N_MST - 1);
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr   <= w_winner;
            r_idx   <= w_winner;
            r_we    <= m_we_i[w_winner];
            r_addr  <= m_addr_i[int'(w_winner)*ADDR_W +: ADDR_W];
            r_wdata <= m_wdata_i[int'(w_winner)*DATA_W +: DATA_W];
            r_be    <= m_be_i[int'(w_winner)*BE_W +: BE_W];
            r_err   <= 1'b0;
          end
        end
        S_ACCESS: begin
          r_err <= !w_inRange;
          r_cnt <= CNT_W'(RAM_LAT - 1);
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= ram_rdata_i;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
